// File: rtl/branch_update_queue_if.sv
// Handshake bundle between fetch/execute and the branch update queue.
interface branch_update_queue_if #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int PHT_W = 7,
  parameter int BHT_W = 4
);
  localparam int TAG_W = $clog2(DEPTH);

  logic             alloc_valid;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic [PC_W-1:0]  alloc_pc;
  logic             alloc_taken;
  logic [PC_W-1:0]  alloc_target;
  logic [PHT_W-1:0] alloc_PHT_index;
  logic [BHT_W-1:0] alloc_BHT_index;

  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             resolve_taken;
  logic [PC_W-1:0]  resolve_target;

  logic             update_en;
  logic [PHT_W-1:0] update_PHT_index;
  logic [BHT_W-1:0] update_BHT_index;
  logic             branch_en;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [TAG_W:0]   count;

  // Pipeline side: drives pushes and resolves, observes updates/redirects.
  modport master (
    output alloc_valid, alloc_pc, alloc_taken, alloc_target, alloc_PHT_index, alloc_BHT_index,
    output resolve_valid, resolve_tag, resolve_taken, resolve_target,
    input  alloc_ready, alloc_tag,
    input  update_en, update_PHT_index, update_BHT_index, branch_en,
    input  mispredict, redirect_pc, count
  );

  // Queue side.
  modport slave (
    input  alloc_valid, alloc_pc, alloc_taken, alloc_target, alloc_PHT_index, alloc_BHT_index,
    input  resolve_valid, resolve_tag, resolve_taken, resolve_target,
    output alloc_ready, alloc_tag,
    output update_en, update_PHT_index, update_BHT_index, branch_en,
    output mispredict, redirect_pc, count
  );
endinterface

// File: rtl/branch_update_queue.sv
// Branch update queue: holds predicted branches from fetch until resolved, retires them in
// program order into the predictor update port, and flushes younger entries on a mispredict.
module branch_update_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int PHT_W = 7,
  parameter int BHT_W = 4
) (
  input logic                  clk,
  input logic                  resetn,
  branch_update_queue_if.slave bus
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(DEPTH);

  typedef logic [TAG_W-1:0] tag_t;

  // Control state
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] resolved_q, resolved_d;
  tag_t             head_q, head_d;
  tag_t             tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;

  // Entry payload (meaningful only while the slot is valid, so no reset)
  logic [PC_W-1:0]  pc_q [DEPTH];
  logic [PC_W-1:0]  pc_d [DEPTH];
  logic             pred_taken_q [DEPTH];
  logic             pred_taken_d [DEPTH];
  logic [PC_W-1:0]  pred_target_q [DEPTH];
  logic [PC_W-1:0]  pred_target_d [DEPTH];
  logic [PHT_W-1:0] pht_idx_q [DEPTH];
  logic [PHT_W-1:0] pht_idx_d [DEPTH];
  logic [BHT_W-1:0] bht_idx_q [DEPTH];
  logic [BHT_W-1:0] bht_idx_d [DEPTH];
  logic             act_taken_q [DEPTH];
  logic             act_taken_d [DEPTH];
  logic [PC_W-1:0]  act_target_q [DEPTH];
  logic [PC_W-1:0]  act_target_d [DEPTH];

  // Registered outputs
  logic             update_en_q, update_en_d;
  logic [PHT_W-1:0] update_pht_q, update_pht_d;
  logic [BHT_W-1:0] update_bht_q, update_bht_d;
  logic             branch_en_q, branch_en_d;
  logic             mispredict_q, mispredict_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;

  logic retire;
  logic retire_mp;
  logic alloc_ok;
  logic push;
  logic do_resolve;

  // Retire/flush decisions come from registered state only; a flush blocks push and resolve.
  always_comb begin
    retire    = valid_q[head_q] && resolved_q[head_q];
    retire_mp = retire &&
                ((pred_taken_q[head_q] != act_taken_q[head_q]) ||
                 (act_taken_q[head_q] && (pred_target_q[head_q] != act_target_q[head_q])));
    alloc_ok   = (count_q != CNT_FULL) && !retire_mp;
    push       = bus.alloc_valid && alloc_ok;
    do_resolve = bus.resolve_valid && valid_q[bus.resolve_tag] && !retire_mp;
  end

  // Next-state for queue entries, pointers, count and the registered update/redirect port.
  always_comb begin
    valid_d       = valid_q;
    resolved_d    = resolved_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    pc_d          = pc_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    pht_idx_d     = pht_idx_q;
    bht_idx_d     = bht_idx_q;
    act_taken_d   = act_taken_q;
    act_target_d  = act_target_q;
    update_en_d   = 1'b0;
    update_pht_d  = update_pht_q;
    update_bht_d  = update_bht_q;
    branch_en_d   = branch_en_q;
    mispredict_d  = 1'b0;
    redirect_pc_d = redirect_pc_q;

    if (do_resolve) begin
      resolved_d[bus.resolve_tag]   = 1'b1;
      act_taken_d[bus.resolve_tag]  = bus.resolve_taken;
      act_target_d[bus.resolve_tag] = bus.resolve_target;
    end

    if (retire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + tag_t'(1);
      update_en_d     = 1'b1;
      update_pht_d    = pht_idx_q[head_q];
      update_bht_d    = bht_idx_q[head_q];
      branch_en_d     = act_taken_q[head_q];
    end

    // Flush: everything younger than the retiring head is discarded.
    if (retire_mp) begin
      valid_d       = '0;
      tail_d        = head_q + tag_t'(1);
      mispredict_d  = 1'b1;
      redirect_pc_d = act_taken_q[head_q] ? act_target_q[head_q]
                                          : pc_q[head_q] + PC_W'(4);
    end

    if (push) begin
      valid_d[tail_q]       = 1'b1;
      resolved_d[tail_q]    = 1'b0;
      pc_d[tail_q]          = bus.alloc_pc;
      pred_taken_d[tail_q]  = bus.alloc_taken;
      pred_target_d[tail_q] = bus.alloc_target;
      pht_idx_d[tail_q]     = bus.alloc_PHT_index;
      bht_idx_d[tail_q]     = bus.alloc_BHT_index;
      tail_d                = tail_q + tag_t'(1);
    end

    if (retire_mp) begin
      count_d = '0;
    end else if (push && !retire) begin
      count_d = count_q + 1'b1;
    end else if (retire && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q       <= '0;
      resolved_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      update_en_q   <= 1'b0;
      update_pht_q  <= '0;
      update_bht_q  <= '0;
      branch_en_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      valid_q       <= valid_d;
      resolved_q    <= resolved_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      update_en_q   <= update_en_d;
      update_pht_q  <= update_pht_d;
      update_bht_q  <= update_bht_d;
      branch_en_q   <= branch_en_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    pc_q          <= pc_d;
    pred_taken_q  <= pred_taken_d;
    pred_target_q <= pred_target_d;
    pht_idx_q     <= pht_idx_d;
    bht_idx_q     <= bht_idx_d;
    act_taken_q   <= act_taken_d;
    act_target_q  <= act_target_d;
  end

  assign bus.alloc_ready      = alloc_ok;
  assign bus.alloc_tag        = tail_q;
  assign bus.update_en        = update_en_q;
  assign bus.update_PHT_index = update_pht_q;
  assign bus.update_BHT_index = update_bht_q;
  assign bus.branch_en        = branch_en_q;
  assign bus.mispredict       = mispredict_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.count            = count_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Bench for branch_update_queue: directed scenarios plus a randomized run, all compared
// against an in-order queue model of the in-flight branches.
module tb_branch_update_queue;
  localparam int DEPTH = 8;
  localparam int PC_W  = 32;
  localparam int PHT_W = 7;
  localparam int BHT_W = 4;
  localparam int TAG_W = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  branch_update_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .PHT_W(PHT_W), .BHT_W(BHT_W)) bus ();

  branch_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .PHT_W(PHT_W), .BHT_W(BHT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic [6:0]  pht;
    logic [3:0]  bht;
    bit          res;
    logic        at;
    logic [31:0] atgt;
  } ent_t;

  ent_t mq[$];
  int   m_tail;
  logic e_upd, e_ben, e_mp;
  logic [6:0]  e_pht;
  logic [3:0]  e_bht;
  logic [31:0] e_rpc;

  int checks = 0;
  int errors = 0;

  logic        a_v = 0, a_t = 0, r_v = 0, r_t = 0;
  logic [31:0] a_pc = 0, a_tgt = 0, r_tgt = 0;
  logic [6:0]  a_pht = 0;
  logic [3:0]  a_bht = 0;
  int          r_tag = 0;

  logic        o_rdy, o_upd, o_ben, o_mp;
  logic [2:0]  o_tag;
  logic [6:0]  o_pht;
  logic [3:0]  o_bht;
  logic [31:0] o_rpc;
  logic [3:0]  o_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit front_mp();
    if (mq.size() > 0 && mq[0].res)
      return (mq[0].pt != mq[0].at) || (mq[0].at && mq[0].ptgt != mq[0].atgt);
    return 0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    e_upd = 0; e_ben = 0; e_mp = 0; e_pht = 0; e_bht = 0; e_rpc = 0;
  endtask

  task automatic model_step(input bit rdy);
    ent_t f;
    ent_t n;
    bit ret, mp, psh;
    ret = (mq.size() > 0) && mq[0].res;
    mp  = front_mp();
    psh = a_v && rdy;
    if (ret) f = mq[0];
    if (r_v && !mp) begin
      foreach (mq[i]) if (mq[i].tag == r_tag) begin
        mq[i].res = 1; mq[i].at = r_t; mq[i].atgt = r_tgt;
      end
    end
    e_upd = ret;
    e_mp  = mp;
    if (ret) begin
      e_pht = f.pht; e_bht = f.bht; e_ben = f.at;
      void'(mq.pop_front());
    end
    if (mp) begin
      e_rpc = f.at ? f.atgt : f.pc + 32'd4;
      mq.delete();
      m_tail = (f.tag + 1) % DEPTH;
    end
    if (psh) begin
      n = '{tag: m_tail, pc: a_pc, pt: a_t, ptgt: a_tgt, pht: a_pht, bht: a_bht,
            res: 0, at: 0, atgt: 0};
      mq.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, step model on posedge,
  // then check registered outputs just after the edge.
  task automatic tick();
    bit rdy_exp;
    bus.alloc_valid     = a_v;
    bus.alloc_pc        = a_pc;
    bus.alloc_taken     = a_t;
    bus.alloc_target    = a_tgt;
    bus.alloc_PHT_index = a_pht;
    bus.alloc_BHT_index = a_bht;
    bus.resolve_valid   = r_v;
    bus.resolve_tag     = TAG_W'(r_tag);
    bus.resolve_taken   = r_t;
    bus.resolve_target  = r_tgt;
    #1;
    rdy_exp = (mq.size() != DEPTH) && !front_mp();
    o_rdy = bus.alloc_ready;
    o_tag = bus.alloc_tag;
    chk("alloc_ready", o_rdy, rdy_exp);
    chk("alloc_tag", o_tag, m_tail);
    @(posedge clk);
    model_step(rdy_exp);
    #1;
    o_cnt = bus.count; o_upd = bus.update_en; o_pht = bus.update_PHT_index;
    o_bht = bus.update_BHT_index; o_ben = bus.branch_en; o_mp = bus.mispredict;
    o_rpc = bus.redirect_pc;
    chk("count", o_cnt, mq.size());
    chk("update_en", o_upd, e_upd);
    chk("update_PHT_index", o_pht, e_pht);
    chk("update_BHT_index", o_bht, e_bht);
    chk("branch_en", o_ben, e_ben);
    chk("mispredict", o_mp, e_mp);
    chk("redirect_pc", o_rpc, e_rpc);
    @(negedge clk);
    a_v = 0; r_v = 0;
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                      input logic [6:0] pht, input logic [3:0] bht);
    a_v = 1; a_pc = pc; a_t = t; a_tgt = tgt; a_pht = pht; a_bht = bht;
    tick();
  endtask

  task automatic resolve(input int tag, input logic t, input logic [31:0] tgt);
    r_v = 1; r_tag = tag; r_t = t; r_tgt = tgt;
    tick();
  endtask

  // Reset asserted mid-cycle so the asynchronous path is what clears the outputs.
  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_update_en", bus.update_en, 0);
    chk("rst_mispredict", bus.mispredict, 0);
    model_reset();
    @(negedge clk);
    resetn = 1;
    #1;
    chk("rst_alloc_ready", bus.alloc_ready, 1);
    chk("rst_alloc_tag", bus.alloc_tag, 0);
  endtask

  initial begin
    bus.alloc_valid = 0; bus.resolve_valid = 0;
    bus.alloc_pc = 0; bus.alloc_taken = 0; bus.alloc_target = 0;
    bus.alloc_PHT_index = 0; bus.alloc_BHT_index = 0;
    bus.resolve_tag = 0; bus.resolve_taken = 0; bus.resolve_target = 0;
    model_reset();

    // Simple correct prediction
    do_reset();
    push(32'h100, 0, 0, 7'h15, 4'h3);
    resolve(0, 0, 0);
    tick();
    chk("t1_update_en", o_upd, 1);
    chk("t1_pht", o_pht, 7'h15);
    chk("t1_bht", o_bht, 4'h3);
    chk("t1_branch_en", o_ben, 0);
    chk("t1_mispredict", o_mp, 0);

    // Out-of-order resolve, in-order retire
    do_reset();
    push(32'h110, 0, 0, 7'h10, 4'h1);
    push(32'h120, 1, 32'h800, 7'h11, 4'h2);
    push(32'h130, 0, 0, 7'h12, 4'h3);
    resolve(2, 0, 0);
    resolve(0, 0, 0);
    chk("t2_no_early_retire", o_upd, 0);
    resolve(1, 1, 32'h800);
    chk("t2_first_pht", o_pht, 7'h10);
    tick();
    chk("t2_second_pht", o_pht, 7'h11);
    chk("t2_second_ben", o_ben, 1);
    tick();
    chk("t2_third_pht", o_pht, 7'h12);
    chk("t2_count_empty", o_cnt, 0);

    // Direction mispredict flushes younger entries
    do_reset();
    push(32'h200, 0, 0, 7'h20, 4'h4);
    push(32'h204, 0, 0, 7'h21, 4'h5);
    push(32'h208, 0, 0, 7'h22, 4'h6);
    resolve(0, 1, 32'h400);
    a_v = 1; a_pc = 32'h300;
    tick();
    chk("t3_ready_in_flush", o_rdy, 0);
    chk("t3_mispredict", o_mp, 1);
    chk("t3_redirect", o_rpc, 32'h400);
    chk("t3_count", o_cnt, 0);
    resolve(1, 0, 0);
    resolve(2, 0, 0);
    tick();
    chk("t3_ignored_update", o_upd, 0);
    chk("t3_ignored_count", o_cnt, 0);

    // Target mispredict, and taken-predicted but not taken
    do_reset();
    push(32'h600, 1, 32'h300, 7'h30, 4'h7);
    resolve(0, 1, 32'h304);
    tick();
    chk("t4_tgt_mispredict", o_mp, 1);
    chk("t4_tgt_redirect", o_rpc, 32'h304);
    push(32'h500, 1, 32'h700, 7'h31, 4'h8);
    resolve(1, 0, 0);
    tick();
    chk("t4_nt_redirect", o_rpc, 32'h504);

    // Full queue, no bypass, tag wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i * 4), 0, 0, 7'(i), 4'(i));
    tick();
    chk("t5_full_ready", o_rdy, 0);
    chk("t5_full_count", o_cnt, 8);
    resolve(0, 0, 0);
    a_v = 1; a_pc = 32'h2000;
    tick();
    chk("t5_no_bypass", o_rdy, 0);
    chk("t5_count_after_retire", o_cnt, 7);
    push(32'h2000, 0, 0, 7'h40, 4'h9);
    chk("t5_ready_wrap", o_rdy, 1);
    chk("t5_tag_wrap", o_tag, 0);
    chk("t5_count_refill", o_cnt, 8);

    // Asynchronous reset with entries in flight and an update pending on the port
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h3000 + 32'(i * 4), 0, 0, 7'(i + 8), 4'(i));
    resolve(0, 0, 0);
    tick();
    chk("t6_update_before_reset", o_upd, 1);
    do_reset();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      a_v = ($urandom_range(0, 3) != 0);
      a_pc = $urandom & 32'hFFFF_FFFC;
      a_t = $urandom_range(0, 1);
      a_tgt = $urandom_range(0, 1) ? 32'h1000 : 32'h2000;
      a_pht = 7'($urandom);
      a_bht = 4'($urandom);
      r_v = ($urandom_range(0, 2) != 0);
      if (mq.size() > 0 && $urandom_range(0, 7) != 0) begin
        int k;
        k = $urandom_range(0, mq.size() - 1);
        r_tag = mq[k].tag;
        if ($urandom_range(0, 5) != 0) begin
          r_t = mq[k].pt; r_tgt = mq[k].ptgt;
        end else begin
          r_t = $urandom_range(0, 1);
          r_tgt = $urandom_range(0, 1) ? 32'h1000 : 32'h3000;
        end
      end else begin
        r_tag = $urandom_range(0, DEPTH - 1);
        r_t = $urandom_range(0, 1);
        r_tgt = 32'h1000;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
